// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state enum, instruction/PC widths and the bubble and halt encodings.
package fetch_pkg;
   localparam int INSTR_W = 16;
   localparam int PC_W    = 16;

   localparam logic [PC_W-1:0]    RESET_PC_C   = 16'h0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR_C  = 16'hE000;
   localparam logic [3:0]         HLT_OPCODE_C = 4'hF;

   typedef enum logic [2:0] {
      FETCH,
      WAIT,
      HOLD,
      DRAIN,
      HALT
   } fetch_state_t;
endpackage

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: bubble loads NOP with valid=0, load captures {pc, instr} with valid=1.
// No added latency beyond the register itself; holds contents when neither bubble nor load is asserted.
module fetch_decode_reg
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_C,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               bubble,
   input  logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    curr_pc,
   output logic [INSTR_W-1:0] curr_instr,
   output logic               valid
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         curr_pc    <= RESET_PC;
         curr_instr <= NOP_INSTR;
         valid      <= 1'b0;
      end else if (bubble) begin
         // The PC field keeps its last value; only the instruction is replaced.
         curr_instr <= NOP_INSTR;
         valid      <= 1'b0;
      end else if (load) begin
         curr_pc    <= pc;
         curr_instr <= instr;
         valid      <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, issues one imem request at a time (>=2 cycles/instr), parks after HLT.
// Decode stall holds IF/ID (response buffered in HOLD); flush redirects. FETCH_PERF_CNT_EN adds counters.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC   = RESET_PC_C,
   parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_INSTR_C,
   parameter logic [3:0]         HLT_OPCODE = HLT_OPCODE_C
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    branch_pc,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic [PC_W-1:0]    curr_pc_fd,
   output logic [INSTR_W-1:0] curr_instr_fd,
   output logic               fd_valid,
   output logic               halted,
   output logic [15:0]        fetch_count,
   output logic [15:0]        bubble_count
);

   fetch_state_t        state, state_nxt;
   logic [PC_W-1:0]     pc, pc_nxt, pc_inc;
   logic [INSTR_W-1:0]  buf_q, buf_nxt, ready_instr;
   logic                ready, fetch_req, if_load, if_bubble;

   assign pc_inc = pc + PC_W'(2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH;
         pc    <= RESET_PC;
         buf_q <= NOP_INSTR;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         buf_q <= buf_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      buf_nxt     = buf_q;
      ready       = 1'b0;
      ready_instr = buf_q;
      fetch_req   = 1'b0;
      case (state)
         FETCH: begin
            // A redirect in the request cycle suppresses the request entirely.
            if (flush) begin
               pc_nxt = branch_pc;
            end else begin
               fetch_req = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            ready_instr = imem_rdata;
            if (imem_valid) begin
               if (flush) begin
                  pc_nxt    = branch_pc;
                  state_nxt = FETCH;
               end else if (stall) begin
                  buf_nxt   = imem_rdata;
                  state_nxt = HOLD;
               end else begin
                  ready     = 1'b1;
                  pc_nxt    = pc_inc;
                  state_nxt = (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE) ? HALT : FETCH;
               end
            end else if (flush) begin
               pc_nxt    = branch_pc;
               state_nxt = DRAIN;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_nxt    = branch_pc;
               state_nxt = FETCH;
            end else if (!stall) begin
               ready     = 1'b1;
               pc_nxt    = pc_inc;
               state_nxt = (buf_q[INSTR_W-1 -: 4] == HLT_OPCODE) ? HALT : FETCH;
            end
         end
         DRAIN: begin
            // The response to the abandoned request must be swallowed before a new one goes out.
            if (flush) pc_nxt = branch_pc;
            if (imem_valid) state_nxt = FETCH;
         end
         HALT: begin
            if (flush) begin
               pc_nxt    = branch_pc;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   assign imem_req  = fetch_req & rst;
   assign imem_addr = pc;
   assign halted    = (state == HALT);

   assign if_load   = ready;
   assign if_bubble = flush | (~stall & ~ready);

   fetch_decode_reg #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_fd_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (if_load),
      .bubble     (if_bubble),
      .pc         (pc),
      .instr      (ready_instr),
      .curr_pc    (curr_pc_fd),
      .curr_instr (curr_instr_fd),
      .valid      (fd_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q  <= 16'h0000;
         bubble_cnt_q <= 16'h0000;
      end else begin
         if (if_load && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'h0001;
         if (if_bubble && bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'h0001;
      end
   end

   assign fetch_count  = fetch_cnt_q;
   assign bubble_count = bubble_cnt_q;
`else
   assign fetch_count  = 16'h0000;
   assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural imem with programmable latency, event log and stream model.
module tb_fetch_stage;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, flush = 1'b0, imem_valid = 1'b0;
   logic [15:0] branch_pc = 16'h0000, imem_rdata = 16'h0000;
   logic        imem_req, fd_valid, halted;
   logic [15:0] imem_addr, curr_pc_fd, curr_instr_fd, fetch_count, bubble_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_pc     (branch_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_valid    (imem_valid),
      .curr_pc_fd    (curr_pc_fd),
      .curr_instr_fd (curr_instr_fd),
      .fd_valid      (fd_valid),
      .halted        (halted),
      .fetch_count   (fetch_count),
      .bubble_count  (bubble_count)
   );

   logic [15:0] mem [0:255];
   int          lat_mode = 1;   // 0 = random 1..4 per request
   int          proto_err = 0;

   function automatic logic [15:0] mem_at(input logic [15:0] a);
      return mem[a[8:1]];
   endfunction

   // Instruction memory: independent of reset, so a pre-reset request can still answer later.
   initial begin : imem_model
      logic        pend, req_seen;
      logic [15:0] paddr, addr_seen;
      int          cnt;
      pend = 1'b0; paddr = 16'h0; cnt = 0;
      forever begin
         @(negedge clk);
         req_seen  = imem_req;
         addr_seen = imem_addr;
         @(posedge clk);
         #1;
         imem_valid = 1'b0;
         if (req_seen) begin
            if (pend) proto_err++;
            pend  = 1'b1;
            paddr = addr_seen;
            cnt   = (lat_mode == 0) ? int'($urandom_range(4, 1)) : lat_mode;
         end
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_valid = 1'b1;
               imem_rdata = mem_at(paddr);
               pend       = 1'b0;
            end
         end
      end
   end

   // Event log: kind 0 = IF/ID delivery, 1 = redirect, 2 = imem request.
   typedef struct {
      int          kind;
      logic [15:0] a;
      logic [15:0] d;
   } ev_t;
   ev_t log_q[$];
   int  ndel = 0, nbub = 0;

   initial begin : monitor
      logic ld_prev;
      ld_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ndel = 0; nbub = 0; ld_prev = 1'b0;
         end else begin
            if (ld_prev) begin
               if (fd_valid) begin
                  ndel++;
                  log_q.push_back('{0, curr_pc_fd, curr_instr_fd});
               end else begin
                  nbub++;
               end
            end
            if (flush)    log_q.push_back('{1, branch_pc, 16'h0000});
            if (imem_req) log_q.push_back('{2, imem_addr, 16'h0000});
            ld_prev = flush | ~stall;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lm);
      rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_pc = 16'h0000; lat_mode = lm;
      repeat (6) tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 1'b0; flush = 1'b0; lat_mode = 1;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({fd_valid, halted, imem_req, curr_pc_fd, curr_instr_fd} !== {3'b000, RESET_PC_C, NOP_INSTR_C}) begin
         errors++;
         $display("FAIL reset_state: got v=%b h=%b req=%b pc=%h ins=%h, want 0 0 0 %h %h",
                  fd_valid, halted, imem_req, curr_pc_fd, curr_instr_fd, RESET_PC_C, NOP_INSTR_C);
      end
      checks++;
      if ({fetch_count, bubble_count} !== 32'h0) begin
         errors++;
         $display("FAIL reset_counters: got %h/%h want 0/0", fetch_count, bubble_count);
      end
      // Reset in WAIT with a slow response outstanding; stale data lands in FETCH under a held redirect.
      tick(); rst = 1'b1; lat_mode = 4;
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL reset_first_req: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({fd_valid, halted, imem_req, curr_instr_fd} !== {3'b000, NOP_INSTR_C}) begin
         errors++;
         $display("FAIL reset_mid_txn: got v=%b h=%b req=%b ins=%h", fd_valid, halted, imem_req, curr_instr_fd);
      end
      tick();
      rst = 1'b1; flush = 1'b1; branch_pc = 16'h0000;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({fd_valid, imem_req} !== 2'b00) begin
         errors++;
         $display("FAIL reset_stale_ignored: got v=%b req=%b want 0 0", fd_valid, imem_req);
      end
      tick();
      flush = 1'b0; lat_mode = 1;
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL reset_refetch: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
      end
      tick(); tick();
      @(negedge clk);
      checks++;
      if ({fd_valid, curr_pc_fd, curr_instr_fd} !== {1'b1, 16'h0000, mem[0]}) begin
         errors++;
         $display("FAIL reset_fresh_data: got v=%b pc=%h ins=%h want 1 0000 %h", fd_valid, curr_pc_fd, curr_instr_fd, mem[0]);
      end
   endtask

   task automatic test_program();
      logic [15:0] exp_pc, exp_ins;
      mem[0] = 16'h1123;   // ADD
      mem[1] = 16'h2456;   // SUB
      mem[2] = 16'hF000;   // HLT
      do_reset(1);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (fd_valid !== (c == 2 || c == 4 || c == 6)) begin
            errors++;
            $display("FAIL prog_valid c%0d: got %b", c, fd_valid);
         end
         checks++;
         if (imem_req !== (c < 6 && c % 2 == 0) || halted !== (c >= 6)) begin
            errors++;
            $display("FAIL prog_req_halt c%0d: got req=%b halted=%b", c, imem_req, halted);
         end
         if (c == 2 || c == 4 || c == 6) begin
            exp_pc  = 16'((c - 2) / 2 * 2);
            exp_ins = mem[(c - 2) / 2];
            checks++;
            if ({curr_pc_fd, curr_instr_fd} !== {exp_pc, exp_ins}) begin
               errors++;
               $display("FAIL prog_deliver c%0d: got %h/%h want %h/%h", c, curr_pc_fd, curr_instr_fd, exp_pc, exp_ins);
            end
         end
         tick();
      end
   endtask

   task automatic test_halt_flush();
      flush = 1'b1; branch_pc = 16'h0010;
      @(negedge clk);
      checks++;
      if ({halted, imem_req} !== 2'b10) begin
         errors++;
         $display("FAIL halt_before: got halted=%b req=%b want 1 0", halted, imem_req);
      end
      tick();
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if ({halted, imem_req, imem_addr} !== {2'b01, 16'h0010}) begin
         errors++;
         $display("FAIL halt_resume: got halted=%b req=%b addr=%h want 0 1 0010", halted, imem_req, imem_addr);
      end
      tick(); tick();
      @(negedge clk);
      checks++;
      if ({fd_valid, curr_pc_fd, curr_instr_fd} !== {1'b1, 16'h0010, mem[8]}) begin
         errors++;
         $display("FAIL halt_first_instr: got %b %h %h want 1 0010 %h", fd_valid, curr_pc_fd, curr_instr_fd, mem[8]);
      end
   endtask

   task automatic test_stall();
      logic [15:0] exp_f, exp_b;
      do_reset(1);
      tick();
      tick(); stall = 1'b1;
      for (int c = 2; c < 6; c++) begin
         if (c == 5) stall = 1'b0;
         @(negedge clk);
         checks++;
         if ({fd_valid, curr_pc_fd, curr_instr_fd} !== {1'b1, 16'h0000, mem[0]}) begin
            errors++;
            $display("FAIL stall_hold c%0d: got %b %h %h want 1 0000 %h", c, fd_valid, curr_pc_fd, curr_instr_fd, mem[0]);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if ({fd_valid, curr_pc_fd, curr_instr_fd} !== {1'b1, 16'h0002, mem[1]}) begin
         errors++;
         $display("FAIL stall_release: got %b %h %h want 1 0002 %h", fd_valid, curr_pc_fd, curr_instr_fd, mem[1]);
      end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin
         errors++;
         $display("FAIL stall_pc_once: got req=%b addr=%h want 1 0004", imem_req, imem_addr);
      end
      #1;
`ifdef FETCH_PERF_CNT_EN
      exp_f = 16'(ndel); exp_b = 16'(nbub);
`else
      exp_f = 16'h0; exp_b = 16'h0;
`endif
      checks++;
      if ({fetch_count, bubble_count} !== {exp_f, exp_b}) begin
         errors++;
         $display("FAIL stall_counters: got %0d/%0d want %0d/%0d", fetch_count, bubble_count, exp_f, exp_b);
      end
   endtask

   task automatic test_flush();
      logic [15:0] exp_f, exp_b;
      do_reset(4);
      tick();
      flush = 1'b1; branch_pc = 16'h0040;
      tick();
      flush = 1'b0;
      for (int c = 2; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({fd_valid, curr_instr_fd} !== {1'b0, NOP_INSTR_C}) begin
            errors++;
            $display("FAIL flush_bubble c%0d: got %b %h want 0 %h", c, fd_valid, curr_instr_fd, NOP_INSTR_C);
         end
         checks++;
         if ({imem_req, imem_addr} !== ((c == 5) ? {1'b1, 16'h0040} : {1'b0, imem_addr})) begin
            errors++;
            $display("FAIL flush_req c%0d: got req=%b addr=%h", c, imem_req, imem_addr);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if ({fd_valid, curr_pc_fd, curr_instr_fd} !== {1'b1, 16'h0040, mem[32]}) begin
         errors++;
         $display("FAIL flush_target: got %b %h %h want 1 0040 %h", fd_valid, curr_pc_fd, curr_instr_fd, mem[32]);
      end
      #1;
`ifdef FETCH_PERF_CNT_EN
      exp_f = 16'(ndel); exp_b = 16'(nbub);
`else
      exp_f = 16'h0; exp_b = 16'h0;
`endif
      checks++;
      if ({fetch_count, bubble_count} !== {exp_f, exp_b}) begin
         errors++;
         $display("FAIL flush_counters: got %0d/%0d want %0d/%0d", fetch_count, bubble_count, exp_f, exp_b);
      end
   endtask

   task automatic test_flush_stall();
      do_reset(1);
      tick(); tick();
      stall = 1'b1; flush = 1'b1; branch_pc = 16'h0020;
      @(negedge clk);
      checks++;
      if (fd_valid !== 1'b1) begin
         errors++;
         $display("FAIL fs_before: got v=%b want 1", fd_valid);
      end
      tick();
      stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks++;
      if ({fd_valid, curr_instr_fd, imem_req, imem_addr} !== {1'b0, NOP_INSTR_C, 1'b1, 16'h0020}) begin
         errors++;
         $display("FAIL fs_priority: got v=%b ins=%h req=%b addr=%h want 0 %h 1 0020",
                  fd_valid, curr_instr_fd, imem_req, imem_addr, NOP_INSTR_C);
      end
   endtask

   task automatic test_wrap();
      do_reset(1);
      flush = 1'b1; branch_pc = 16'hFFFE;
      tick();
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 16'hFFFE}) begin
         errors++;
         $display("FAIL wrap_req: got req=%b addr=%h want 1 fffe", imem_req, imem_addr);
      end
      tick(); tick();
      @(negedge clk);
      checks++;
      if ({fd_valid, curr_pc_fd, curr_instr_fd, imem_req, imem_addr} !== {1'b1, 16'hFFFE, mem[255], 1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_next: got %b %h %h req=%b addr=%h want 1 fffe %h 1 0000",
                  fd_valid, curr_pc_fd, curr_instr_fd, imem_req, imem_addr, mem[255]);
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_pc, exp_ins, exp_f, exp_b;
      logic        halted_exp;
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(99, 0) < 10) ? {4'hF, 12'($urandom)} : {4'($urandom_range(14, 0)), 12'($urandom)};
      do_reset(0);
      log_q.delete();
      for (int c = 0; c < 600; c++) begin
         stall     = ($urandom_range(99, 0) < 30);
         flush     = ($urandom_range(99, 0) < 8);
         branch_pc = 16'($urandom_range(255, 0)) << 1;
         tick();
      end
      stall = 1'b0; flush = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      #1;
      exp_pc = RESET_PC_C;
      halted_exp = 1'b0;
      foreach (log_q[i]) begin
         if (log_q[i].kind == 1) begin
            exp_pc = log_q[i].a;
            halted_exp = 1'b0;
         end else if (log_q[i].kind == 2) begin
            checks++;
            if (halted_exp || log_q[i].a !== exp_pc) begin
               errors++;
               $display("FAIL rand_req ev%0d: got addr=%h want %h (halted_exp=%b)", i, log_q[i].a, exp_pc, halted_exp);
            end
         end else begin
            exp_ins = mem_at(exp_pc);
            checks++;
            if (halted_exp || {log_q[i].a, log_q[i].d} !== {exp_pc, exp_ins}) begin
               errors++;
               $display("FAIL rand_deliver ev%0d: got %h/%h want %h/%h (halted_exp=%b)",
                        i, log_q[i].a, log_q[i].d, exp_pc, exp_ins, halted_exp);
               exp_pc = log_q[i].a;
               exp_ins = log_q[i].d;
            end
            halted_exp = (exp_ins[15:12] == HLT_OPCODE_C);
            exp_pc = exp_pc + 16'h0002;
         end
      end
      checks++;
      if (halted !== halted_exp) begin
         errors++;
         $display("FAIL rand_halted: got %b want %b", halted, halted_exp);
      end
      checks++;
      if (proto_err !== 0 || ndel < 20) begin
         errors++;
         $display("FAIL rand_protocol: overlapping requests=%0d deliveries=%0d (want 0 and >=20)", proto_err, ndel);
      end
`ifdef FETCH_PERF_CNT_EN
      exp_f = 16'(ndel); exp_b = 16'(nbub);
`else
      exp_f = 16'h0; exp_b = 16'h0;
`endif
      checks++;
      if ({fetch_count, bubble_count} !== {exp_f, exp_b}) begin
         errors++;
         $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", fetch_count, bubble_count, exp_f, exp_b);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
      test_reset();
      test_program();
      test_halt_flush();
      test_stall();
      test_flush();
      test_flush_stall();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
